// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for a single shared combinational ALU. It grants one requester,
// holds that requester's operands on the ALU for ALU_LAT cycles, then returns the result and the requester ID.
module alu_rr_arbiter #(
  parameter int BITS_DATA = 8,
  parameter int BITS_OP   = 6,
  parameter int N_REQ     = 2,
  parameter int ID_BITS   = 1,
  parameter int ALU_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*BITS_DATA-1:0] i_req_a,
  input  logic [N_REQ*BITS_DATA-1:0] i_req_b,
  input  logic [N_REQ*BITS_OP-1:0]   i_req_op,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic [BITS_DATA-1:0]       o_alu_a,
  output logic [BITS_DATA-1:0]       o_alu_b,
  output logic [BITS_OP-1:0]         o_alu_op,
  input  logic [BITS_DATA-1:0]       i_alu_result,
  output logic                       o_rsp_valid,
  output logic [ID_BITS-1:0]         o_rsp_id,
  output logic [BITS_DATA-1:0]       o_rsp_result,
  input  logic                       i_rsp_ready,
  output logic                       o_busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BITS_DATA-1:0] alu_a_q, alu_a_d;
  logic [BITS_DATA-1:0] alu_b_q, alu_b_d;
  logic [BITS_OP-1:0]   alu_op_q, alu_op_d;
  logic [BITS_DATA-1:0] rsp_result_q, rsp_result_d;
  logic [ID_BITS-1:0]   rsp_id_q, rsp_id_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic                 grant_found;
  logic [ID_BITS-1:0]   grant_id;
  logic [N_REQ-1:0]     grant_onehot;
  logic [N_REQ-1:0]     valid_shift;
  int unsigned          scan_idx;

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    valid_shift = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx    = (32'(ptr_q) + i) % N_REQ;
      valid_shift = i_req_valid >> scan_idx;
      if (!grant_found && valid_shift[0]) begin
        grant_found = 1'b1;
        grant_id    = ID_BITS'(scan_idx);
      end
    end
    grant_onehot = grant_found ? (N_REQ'(1) << grant_id) : '0;
  end

  assign o_req_ready = ((state_q == S_IDLE) && !i_reset) ? grant_onehot : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          alu_a_d  = BITS_DATA'(i_req_a >> (32'(grant_id) * BITS_DATA));
          alu_b_d  = BITS_DATA'(i_req_b >> (32'(grant_id) * BITS_DATA));
          alu_op_d = BITS_OP'(i_req_op >> (32'(grant_id) * BITS_OP));
          rsp_id_d = grant_id;
          ptr_d    = ID_BITS'((32'(grant_id) + 1) % N_REQ);
          cnt_d    = CNT_W'(ALU_LAT - 1);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = i_alu_result;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU core between `N_REQ` requesters. Each requester offers an operand pair and a 6-bit opcode over a valid/ready handshake. The block latches the winning request and drives the ALU inputs for a fixed latency. It then returns the registered result with the requester's ID over a single response channel, and sits between the input front-ends (switch/button loader, serial command decoder) and the ALU.

## Interface
- `BITS_DATA`, 8, operand/result width
- `BITS_OP`, 6, opcode width (passed to ALU unchanged)
- `N_REQ`, 2, number of requesters (2..4)
- `ID_BITS`, 1, response ID width; must be ≥ clog2(`N_REQ`)
- `ALU_LAT`, 1, cycles the ALU inputs are held before the result is sampled (≥1)

- `clk` in 1: single clock, rising edge
- `i_reset` in 1: synchronous, active-high reset
- `i_req_valid` in N_REQ: request valid, one bit per requester
- `i_req_a` in N_REQ*BITS_DATA: operand A, requester k at slice [k*BITS_DATA +: BITS_DATA]
- `i_req_b` in N_REQ*BITS_DATA: operand B, same packing
- `i_req_op` in N_REQ*BITS_OP: opcode, requester k at [k*BITS_OP +: BITS_OP]
- `o_req_ready` out N_REQ: one-hot grant/accept, combinational
- `o_alu_a` out BITS_DATA: registered operand A to ALU
- `o_alu_b` out BITS_DATA: registered operand B to ALU
- `o_alu_op` out BITS_OP: registered opcode to ALU
- `i_alu_result` in BITS_DATA: ALU result (combinational ALU)
- `o_rsp_valid` out 1: response valid
- `o_rsp_id` out ID_BITS: index of requester that owns the response
- `o_rsp_result` out BITS_DATA: registered result
- `i_rsp_ready` in 1: response consumer ready
- `o_busy` out 1: high in every state except IDLE

## Operation
- FSM states:
  - IDLE: `o_req_ready` = one-hot winner among `i_req_valid`, or 0 if none. Transfer on `i_req_valid[k] & o_req_ready[k]`: latch A/B/op into `o_alu_*`, latch k as owner, load the wait counter with `ALU_LAT-1`, go to WAIT.
  - WAIT: `o_alu_*` held stable. When the counter is 0, capture `i_alu_result` into `o_rsp_result`, set `o_rsp_valid`, go to RESP; otherwise decrement.
  - RESP: `o_rsp_valid`=1, and `o_rsp_id`/`o_rsp_result` held stable. On `i_rsp_ready`=1, clear `o_rsp_valid` and go to IDLE.
- Round-robin: the priority pointer p starts at 0. The winner is the first valid index scanning p, p+1, …, wrapping mod `N_REQ`. After a transfer to k, p ← (k+1) mod `N_REQ`. p changes only on transfer.
- `o_req_ready` is 0 in WAIT and RESP; requests are not accepted while busy.
- A requester may drop valid before acceptance; no state is kept for it.
- The opcode is not decoded. Illegal opcodes are forwarded, and the ALU's output (0 for undefined ops) is returned as-is.
- `o_alu_*` retain their last values in IDLE. They are not cleared after an operation.

## Timing
- Reset (`i_reset`=1 at an edge): state IDLE, p=0, and `o_alu_a`/`o_alu_b`/`o_alu_op`/`o_rsp_result`/`o_rsp_id`/`o_rsp_valid` = 0. `o_busy`=0. `o_req_ready` is forced to 0 while `i_reset` is high.
- Reset mid-operation (WAIT or RESP): the in-flight op is discarded, no response is issued, and p returns to 0.
- Accept at edge t. `o_alu_*` are valid from t. The result is sampled at edge t+`ALU_LAT`, and `o_rsp_valid` is high from t+`ALU_LAT`.
- With `i_rsp_ready` held at 1, the response handshake completes at edge t+`ALU_LAT`+1. The next accept can occur at edge t+`ALU_LAT`+2, so ALU_LAT=1 gives one op per 3 cycles.
- If `i_rsp_ready` is already high on the first RESP cycle, the handshake completes that cycle. Back-pressure holds RESP indefinitely.
- Simultaneous valids: only one grant per IDLE cycle. Losers remain pending and win on later IDLE cycles in pointer order.

## Test plan
- Reset: assert `i_reset` for 2 cycles with all valids high → `o_req_ready`=0, `o_rsp_valid`=0, `o_busy`=0, and all data outputs are 0.
- Single op, ALU_LAT=1, ALU attached: req0 A=0x05 B=0x03 op=6'b100000 (ADD) → `o_rsp_valid` 1 cycle after accept, result=0x08, id=0. Repeat with op=6'b100010 (SUB) A=0x03 B=0x05 → 0xFE.
- Fairness: both valid continuously, p=0, ops AND (6'b100100) and OR (6'b100101) with A=0xF0 B=0x3C → grants alternate 0,1,0,1. Responses are id0 0x30 and id1 0xFC, with no two consecutive grants to one requester.
- Back-pressure: `i_rsp_ready`=0 for 5 cycles during RESP → `o_rsp_valid`, id and result stable, and `o_req_ready`=0 throughout. Raise ready → IDLE the next cycle.
- Reset mid-op: accept a req1 XOR (6'b100110), assert `i_reset` in WAIT → no response. The next simultaneous req0/req1 is granted to 0.
- ALU_LAT=3: NOR (6'b100111) A=0x0F B=0xF0 → `o_alu_*` stable for 3 cycles, `o_rsp_valid` rises 3 cycles after accept, result=0x00.
